// File: rtl/fir_pkg.sv
// Shared constants and state encoding for the 2x chroma upsampler.
// Taps are the symmetric 6-tap half-band kernel (21, -52, 159, 159, -52, 21)/256.
package fir_pkg;

  localparam int C0    = 21;
  localparam int C1    = -52;
  localparam int C2    = 159;
  localparam int ROUND = 128;
  localparam int SHIFT = 8;

  typedef enum logic [1:0] {
    FILL,
    RUN,
    FLUSH
  } fir_state_t;

endpackage

// File: rtl/fir_tap6.sv
// Combinational 6-tap interpolator for one channel.
// Produces the rounded odd sample clipped to the unsigned sample range.
module fir_tap6
  import fir_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [5:0][DATA_W-1:0] taps,
  output logic [DATA_W-1:0]      odd
);

  localparam int AW = DATA_W + 11;

  localparam logic signed [AW-1:0] K0 = AW'(C0);
  localparam logic signed [AW-1:0] K1 = AW'(C1);
  localparam logic signed [AW-1:0] K2 = AW'(C2);
  localparam logic signed [AW-1:0] KR = AW'(ROUND);

  logic signed [AW-1:0] t [6];
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] shifted;

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      t[i] = $signed({11'b0, taps[i]});
    end
    acc     = K0 * (t[0] + t[5]) + K1 * (t[1] + t[4]) + K2 * (t[2] + t[3]) + KR;
    shifted = acc >>> SHIFT;
  end

  // Negative results clip to zero, anything above full scale saturates.
  always_comb begin
    if (shifted[AW-1]) begin
      odd = '0;
    end else if (|shifted[AW-2:DATA_W]) begin
      odd = '1;
    end else begin
      odd = shifted[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/fir_upsampler.sv
// 2x horizontal chroma upsampler: per input sample emits {even, odd} pair,
// with edge-clamped 6-sample windows and a four-step flush at line end.
module fir_upsampler
  import fir_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LINE_W = 160,
  parameter int NUM_CH = 2
) (
  input  logic                     CLOCK_50_I,
  input  logic                     Reset,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_even,
  output logic [NUM_CH*DATA_W-1:0] out_odd,
  output logic                     out_sol,
  output logic                     out_eol
);

  localparam int JW = $clog2(LINE_W + 1);

  fir_state_t state, state_nx;
  logic [1:0]    fill_cnt;
  logic [JW-1:0] j_cnt;
  logic [NUM_CH-1:0][5:0][DATA_W-1:0] win;
  logic [NUM_CH-1:0][DATA_W-1:0]      odd_c;

  logic emit;
  logic accept;
  logic advance;
  logic last_j;

  assign emit    = ~out_valid | out_ready;
  assign accept  = in_valid & in_ready;
  assign last_j  = (j_cnt == JW'(LINE_W - 1));
  assign advance = ((state == RUN) & accept) | ((state == FLUSH) & emit);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    fir_tap6 #(.DATA_W(DATA_W)) u_tap (
      .taps (win[c]),
      .odd  (odd_c[c])
    );
  end

  always_ff @(posedge CLOCK_50_I or posedge Reset) begin
    if (Reset) begin
      state <= FILL;
    end else begin
      state <= state_nx;
    end
  end

  // A short line (LINE_W=4) has no RUN phase: the fill already holds every sample.
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        if (accept && fill_cnt == 2'd3) begin
          state_nx = (LINE_W == 4) ? FLUSH : RUN;
        end
      end
      RUN: begin
        in_ready = emit;
        if (accept && j_cnt == JW'(LINE_W - 5)) begin
          state_nx = FLUSH;
        end
      end
      FLUSH: begin
        if (emit && last_j) begin
          state_nx = FILL;
        end
      end
      default: state_nx = FILL;
    endcase
    if (clear) begin
      state_nx = FILL;
    end
  end

  always_ff @(posedge CLOCK_50_I or posedge Reset) begin
    if (Reset) begin
      fill_cnt <= '0;
      j_cnt    <= '0;
    end else if (clear) begin
      fill_cnt <= '0;
      j_cnt    <= '0;
    end else begin
      if (state == FILL && accept) begin
        fill_cnt <= fill_cnt + 2'd1;
      end
      if (advance) begin
        j_cnt <= (state == FLUSH && last_j) ? '0 : j_cnt + JW'(1);
      end
    end
  end

  // Window shifts toward w0; during flush the last sample is replicated into w5.
  always_ff @(posedge CLOCK_50_I or posedge Reset) begin
    if (Reset) begin
      win <= '0;
    end else if (clear) begin
      win <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (state == FILL && accept) begin
          if (fill_cnt == 2'd0) begin
            win[c] <= {6{in_data[c*DATA_W +: DATA_W]}};
          end else begin
            win[c] <= {in_data[c*DATA_W +: DATA_W], win[c][5:1]};
          end
        end else if (advance) begin
          win[c] <= {(state == RUN) ? in_data[c*DATA_W +: DATA_W] : win[c][5], win[c][5:1]};
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50_I or posedge Reset) begin
    if (Reset) begin
      out_valid <= 1'b0;
      out_even  <= '0;
      out_odd   <= '0;
      out_sol   <= 1'b0;
      out_eol   <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
      out_even  <= '0;
      out_odd   <= '0;
      out_sol   <= 1'b0;
      out_eol   <= 1'b0;
    end else if (advance) begin
      out_valid <= 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        out_even[c*DATA_W +: DATA_W] <= win[c][2];
        out_odd[c*DATA_W +: DATA_W]  <= odd_c[c];
      end
      out_sol <= (j_cnt == '0);
      out_eol <= last_j;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_upsampler.sv
// Directed bench for fir_upsampler: filter windows from a vector table, whole
// lines against a clamped-index reference model, plus clear/reset corner cases.
module tb_fir_upsampler;

  localparam int DW = 8;
  localparam int L  = 128;
  localparam int NC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_data;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_even;
  logic [15:0]   out_odd;
  logic          out_sol;
  logic          out_eol;

  always #5 clk = ~clk;

  fir_upsampler #(.DATA_W(DW), .LINE_W(L), .NUM_CH(NC)) dut (
    .CLOCK_50_I (clk),
    .Reset      (rst),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_even   (out_even),
    .out_odd    (out_odd),
    .out_sol    (out_sol),
    .out_eol    (out_eol)
  );

  typedef struct {
    int w [6];
    int exp_odd;
  } win_vec_t;

  logic [7:0] stim     [2][2][L];
  logic [7:0] got_even [2][2][L];
  logic [7:0] got_odd  [2][2][L];
  logic       got_sol  [2][L];
  logic       got_eol  [2][L];

  int errors = 0;
  int checks = 0;
  int sent_lines;
  int got_cnt;
  int flush_bad;
  bit timed_out;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  function automatic int ref_odd(input int w [6]);
    int acc, q;
    acc = 21 * (w[0] + w[5]) - 52 * (w[1] + w[4]) + 159 * (w[2] + w[3]) + 128;
    q   = acc >>> 8;
    if (q < 0)   q = 0;
    if (q > 255) q = 255;
    return q;
  endfunction

  task automatic producer(input int nl, input int pv);
    bit acc;
    for (int l = 0; l < nl; l++) begin
      for (int i = 0; i < L; i++) begin
        in_data = {stim[l][1][i], stim[l][0][i]};
        acc = 1'b0;
        while (!acc && !timed_out) begin
          in_valid = ($urandom_range(99) < pv);
          @(negedge clk);
          acc = in_valid && in_ready;
          @(posedge clk);
          #1;
        end
      end
      sent_lines = l + 1;
    end
    in_valid = 1'b0;
  endtask

  task automatic consumer(input int nl, input int pr);
    int cyc = 0;
    int l, j;
    while (got_cnt < nl * L && !timed_out) begin
      out_ready = ($urandom_range(99) < pr);
      @(negedge clk);
      if (got_cnt < sent_lines * L && in_ready && !(out_valid && out_eol)) flush_bad++;
      if (out_valid && out_ready) begin
        l = got_cnt / L;
        j = got_cnt % L;
        for (int c = 0; c < 2; c++) begin
          got_even[l][c][j] = out_even[c*8 +: 8];
          got_odd[l][c][j]  = out_odd[c*8 +: 8];
        end
        got_sol[l][j] = out_sol;
        got_eol[l][j] = out_eol;
        got_cnt++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (cyc > 6000) timed_out = 1'b1;
    end
    out_ready = 1'b1;
  endtask

  // Runs nl lines through the DUT and compares every output against the model.
  task automatic run_lines(input int nl, input int pv, input int pr);
    int bad, idx;
    int w [6];
    sent_lines = 0;
    got_cnt    = 0;
    flush_bad  = 0;
    timed_out  = 1'b0;
    fork
      producer(nl, pv);
      consumer(nl, pr);
    join
    check("run_timeout", int'(timed_out), 0);
    check("flush_in_ready", flush_bad, 0);
    bad = 0;
    for (int l = 0; l < nl; l++) begin
      for (int j = 0; j < L; j++) begin
        for (int c = 0; c < 2; c++) begin
          for (int d = 0; d < 6; d++) begin
            idx = j + d - 2;
            if (idx < 0) idx = 0;
            if (idx > L - 1) idx = L - 1;
            w[d] = int'(stim[l][c][idx]);
          end
          if (int'(got_odd[l][c][j]) != ref_odd(w) || got_even[l][c][j] != stim[l][c][j]) begin
            if (bad == 0)
              $display("[TB] first model diff line %0d ch %0d j %0d: even=%0d odd=%0d want %0d/%0d",
                       l, c, j, got_even[l][c][j], got_odd[l][c][j], stim[l][c][j], ref_odd(w));
            bad++;
          end
        end
        if (got_sol[l][j] != (j == 0) || got_eol[l][j] != (j == L - 1)) bad++;
      end
    end
    check("line_model", bad, 0);
  endtask

  initial begin
    win_vec_t vecs [7];
    int nsol;

    vecs[0] = '{w: '{0, 0, 255, 255, 0, 0},       exp_odd: 255};
    vecs[1] = '{w: '{0, 255, 0, 0, 0, 0},         exp_odd: 0};
    vecs[2] = '{w: '{0, 0, 0, 255, 255, 255},     exp_odd: 128};
    vecs[3] = '{w: '{10, 20, 30, 40, 50, 60},     exp_odd: 35};
    vecs[4] = '{w: '{100, 100, 100, 100, 100, 100}, exp_odd: 100};
    vecs[5] = '{w: '{255, 0, 255, 0, 255, 0},     exp_odd: 128};
    vecs[6] = '{w: '{255, 255, 0, 0, 255, 255},   exp_odd: 0};

    rst       = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_even", int'(out_even), 0);
    check("rst_out_odd", int'(out_odd), 0);
    check("rst_sol_eol", int'({out_sol, out_eol}), 0);
    check("rst_in_ready", int'(in_ready), 1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Constant line, free running.
    for (int i = 0; i < L; i++) begin
      stim[0][0][i] = 8'd100;
      stim[0][1][i] = 8'd100;
    end
    run_lines(1, 100, 100);
    check("const_even_first", int'(got_even[0][0][0]), 100);
    check("const_odd_first", int'(got_odd[0][1][0]), 100);
    check("const_odd_last", int'(got_odd[0][0][L-1]), 100);
    check("const_sol_first", int'(got_sol[0][0]), 1);
    check("const_eol_last", int'(got_eol[0][L-1]), 1);
    nsol = 0;
    for (int j = 0; j < L; j++) nsol += int'(got_sol[0][j]);
    check("const_sol_count", nsol, 1);

    // Ramp on ch0, constant on ch1.
    for (int i = 0; i < L; i++) begin
      stim[0][0][i] = 8'(2 * i);
      stim[0][1][i] = 8'd10;
    end
    run_lines(1, 100, 100);
    check("ramp_even_j0", int'(got_even[0][0][0]), 0);
    check("ramp_odd_j0", int'(got_odd[0][0][0]), 1);
    check("ramp_odd_j5", int'(got_odd[0][0][5]), 11);
    check("ramp_even_eol", int'(got_even[0][0][L-1]), 254);
    check("ramp_odd_eol", int'(got_odd[0][0][L-1]), 254);
    check("ramp_ch1_odd", int'(got_odd[0][1][7]), 10);

    // Window table: x[0..5] = window, so output j=2 sees exactly that window.
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < L; i++) begin
        stim[0][0][i] = 8'((i < 6) ? vecs[v].w[i] : vecs[v].w[5]);
        stim[0][1][i] = 8'd0;
      end
      run_lines(1, 100, 100);
      check($sformatf("win%0d_even", v), int'(got_even[0][0][2]), vecs[v].w[2]);
      check($sformatf("win%0d_odd", v), int'(got_odd[0][0][2]), vecs[v].exp_odd);
    end

    // Two channels, two back-to-back lines, free running then with backpressure.
    for (int i = 0; i < L; i++) begin
      stim[0][0][i] = 8'd10;
      stim[0][1][i] = 8'(i);
      stim[1][0][i] = 8'd10;
      stim[1][1][i] = 8'(255 - i);
    end
    run_lines(2, 100, 100);
    check("b2b_l1_even_j0", int'(got_even[1][1][0]), 255);
    run_lines(2, 50, 30);
    check("bp_l1_even_eol", int'(got_even[1][1][L-1]), 128);

    // clear while output j=50 is held.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 55; i++) begin
      in_data = {8'(i + 1), 8'(i + 1)};
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("pre_clear_valid", int'(out_valid), 1);
    check("pre_clear_even", int'(out_even[7:0]), 51);
    @(posedge clk);
    #1;
    clear   = 1'b1;
    in_data = {8'd56, 8'd56};
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("clear_out_valid", int'(out_valid), 0);
    check("clear_out_even", int'(out_even), 0);
    check("clear_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < L; i++) begin
      stim[0][0][i] = 8'd33;
      stim[0][1][i] = 8'(2 * i);
    end
    run_lines(1, 100, 100);
    check("after_clear_even", int'(got_even[0][0][0]), 33);
    check("after_clear_odd_j0", int'(got_odd[0][1][0]), 1);

    // Reset pulsed while flushing.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < L; i++) begin
      in_data = {8'd200, 8'd200};
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("rst_flush_out_valid", int'(out_valid), 0);
    check("rst_flush_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < L; i++) begin
      stim[0][0][i] = 8'(3 * (i % 50));
      stim[0][1][i] = 8'd77;
    end
    run_lines(1, 100, 100);
    check("after_rst_sol", int'(got_sol[0][0]), 1);
    check("after_rst_even", int'(got_even[0][1][0]), 77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir_upsampler.md
Name: fir_upsampler

Overview:
Parametrised 2x horizontal chroma upsampler for the decoder's milestone-1 colour path. It accepts one sample per channel per handshake and emits one output per input sample. Each output is an even/odd pair: the even sample is the pass-through, the odd sample comes from the fixed 6-tap filter (21, -52, 159, 159, -52, 21)/256. It generalises the U/V FIR to NUM_CH channels, any DATA_W and any LINE_W, with valid/ready streaming, edge clamping and a line-end flush. It sits between the SRAM read sequencer and the RGB converter.

Parameters:
DATA_W, 8, bits per sample per channel (unsigned).
LINE_W, 160, input samples per line per channel; output is 2*LINE_W pixels; minimum 4.
NUM_CH, 2, independent channels sharing one handshake (U, V).

Ports:
CLOCK_50_I  input  1  system clock, all logic on rising edge.
Reset  input  1  asynchronous, active-high reset.
clear  input  1  synchronous abort; drop the current line and return to FILL.
in_valid  input  1  in_data holds a sample set.
in_ready  output  1  block accepts in_data this cycle.
in_data  input  NUM_CH*DATA_W  channel c at bits [c*DATA_W +: DATA_W].
out_valid  output  1  out_even/out_odd valid.
out_ready  input  1  consumer accepts the output.
out_even  output  NUM_CH*DATA_W  x[j] per channel.
out_odd  output  NUM_CH*DATA_W  interpolated sample between x[j] and x[j+1].
out_sol  output  1  high with j=0.
out_eol  output  1  high with j=LINE_W-1.

Behaviour:
- Reset and clear values: out_valid=0, out_even=0, out_odd=0, out_sol=0, out_eol=0, state=FILL, counters=0, window=0. in_ready follows the state at once: 1 in FILL. clear overrides any handshake in the same cycle.
- Window per channel: w0..w5 = x[j-2..j+3]. Indices are clamped to [0, LINE_W-1].
- Odd arithmetic: acc = 21*(w0+w5) - 52*(w1+w4) + 159*(w2+w3) + 128. acc is signed, DATA_W+11 bits. odd = acc>>>8, clipped to [0, 2^DATA_W-1]. even = w2.
- Advance: emit = ~out_valid | out_ready. On an advance, the output registers load {w2, odd, sol, eol} for the current window and the window shifts left.
- FILL state:
  - in_ready=1.
  - First accept loads all six taps with x0.
  - Each of the next 3 accepts shifts the new sample into w5. After x3 the window is x0,x0,x0,x1,x2,x3.
  - No output is produced; then go to RUN with j=0 and k=4.
- RUN state:
  - in_ready = emit.
  - Advance on in_valid & in_ready: emit j, shift in x[k], j++, k++.
  - After x[LINE_W-1] is accepted, go to FLUSH.
- FLUSH state:
  - in_ready=0.
  - Advance on emit only: w5 is replicated into the shift.
  - Four advances emit j=LINE_W-4 .. LINE_W-1, then go to FILL for the next line.
- Latency: the first output registers 1 cycle after the accept of x4. For LINE_W=4 the path is FILL, then FLUSH directly.
- out_valid stays high and the output is held until out_ready. in_ready must never depend on in_valid.
- Mid-operation Reset: immediate return to the reset values. A partial line is discarded, and the next input is treated as x0.
- Exactly LINE_W out handshakes per line. out_sol and out_eol are each high exactly once per line.

Decomposition:
- Package fir_pkg: tap constants C0=21, C1=-52, C2=159; ROUND=128; SHIFT=8; enum fir_state_t {FILL, RUN, FLUSH}.
- Sub-module fir_tap6:
  - Purely combinational, one per channel, instantiated NUM_CH times via generate.
  - Input: the six taps. Output: the clipped odd sample.
- The top level holds the FSM, counters, window registers and output registers.

Test Plan:
- Constant line of 100, LINE_W=160, out_ready=1 -> 160 outputs, all even=100 and odd=100; sol on the first, eol on the last.
- Ramp x[i]=2i (i<=127) -> interior odd=2j+1; j=0: even=0, odd=1; eol output: even=254, odd=254.
- Clip: window 0,0,255,255,0,0 -> odd=255 (raw 317); window 0,255,0,0,0,0 -> odd=0 (raw negative); window 0,0,0,255,255,255 -> odd=128.
- Backpressure: random out_ready at 30% and in_valid at 50% -> outputs identical to the free-running run, in_ready=0 throughout FLUSH, no sample lost or duplicated.
- Two channels: ch0 constant 10, ch1 ramp -> channels independent and bit-exact to a reference model; two back-to-back lines keep clamping separate per line.
- clear asserted at j=50, and Reset pulsed mid-FLUSH -> out_valid=0 next cycle or immediately; the next line starts with sol and the first window replicated from the new x0.
